// File: rtl/lsu_axi_controller_pkg.sv
// Shared definitions for the LSU AXI controller: instruction-class defines, FSM encodings, AXI constants.
// Also provides fallbacks for the legacy defines when defines.v is not in the build.
`ifndef INST_TYPE_BUS
`define INST_TYPE_BUS 2:0
`endif
`ifndef INST_LOAD
`define INST_LOAD 3'd1
`endif
`ifndef INST_STORE
`define INST_STORE 3'd2
`endif
`ifndef RESET_ENABLE
`define RESET_ENABLE 1'b0
`endif

package lsu_axi_controller_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_AR    = 3'd1;
  localparam logic [2:0] ST_WAIT_R     = 3'd2;
  localparam logic [2:0] ST_WAIT_AW_W  = 3'd3;
  localparam logic [2:0] ST_WAIT_AW    = 3'd4;
  localparam logic [2:0] ST_WAIT_W     = 3'd5;
  localparam logic [2:0] ST_WAIT_B     = 3'd6;
  localparam logic [2:0] ST_WAIT_READY = 3'd7;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef struct packed {
    logic load;
    logic store;
    logic stall;
  } perf_evt_t;

endpackage

// File: rtl/lsu_axi_controller_perf_counters.sv
// Load/store/stall event counters, present only in LSU_PERF_COUNTERS_EN builds.
module lsu_perf_counters
  import lsu_axi_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  perf_evt_t            evt,
  output logic [CNT_WIDTH-1:0] load_cnt,
  output logic [CNT_WIDTH-1:0] store_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == `RESET_ENABLE) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (evt.load)  load_cnt  <= load_cnt  + CNT_WIDTH'(1);
      if (evt.store) store_cnt <= store_cnt + CNT_WIDTH'(1);
      if (evt.stall) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lsu_axi_controller.sv
// Execute-stage load/store sequencer over AXI4 with split accesses and response checking.
// Optional performance counters enabled by defining LSU_PERF_COUNTERS_EN.
module lsu_axi_controller
  import lsu_axi_controller_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned LSU_ID     = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_pre_i,
  output logic                  ready_pre_o,
  output logic                  valid_post_o,
  input  logic                  ready_post_i,
  input  logic [`INST_TYPE_BUS] inst_type_i,
  input  logic                  split_i,
  output logic                  we_o,
  output logic                  rdata_we_o,
  output logic                  beat_o,
  output logic                  err_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ID_WIDTH-1:0]   awid_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [RESP_WIDTH-1:0] bresp_i,
  input  logic [ID_WIDTH-1:0]   bid_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ID_WIDTH-1:0]   arid_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [RESP_WIDTH-1:0] rresp_i,
  input  logic                  rlast_i,
  input  logic [ID_WIDTH-1:0]   rid_i,
  output logic [CNT_WIDTH-1:0]  perf_load_o,
  output logic [CNT_WIDTH-1:0]  perf_store_o,
  output logic [CNT_WIDTH-1:0]  perf_stall_o
);

  logic [2:0] state_q, state_d;
  logic       beat_q, beat_d;
  logic       split_q, split_d;
  logic       err_q, err_d;

  logic is_load, is_store;
  logic r_hs, b_hs, r_bad, b_bad;

  assign is_load  = (inst_type_i == `INST_LOAD);
  assign is_store = (inst_type_i == `INST_STORE);

  assign r_hs  = rvalid_i & rready_o;
  assign b_hs  = bvalid_i & bready_o;
  assign r_bad = (rresp_i != RESP_WIDTH'(AXI_OKAY)) | (rid_i != ID_WIDTH'(LSU_ID)) | ~rlast_i;
  assign b_bad = (bresp_i != RESP_WIDTH'(AXI_OKAY)) | (bid_i != ID_WIDTH'(LSU_ID));

  // All handshake outputs are pure state decodes, so no valid depends on its ready.
  assign ready_pre_o  = (state_q == ST_IDLE);
  assign valid_post_o = (state_q == ST_WAIT_READY);
  assign arvalid_o    = (state_q == ST_WAIT_AR);
  assign rready_o     = (state_q == ST_WAIT_R);
  assign awvalid_o    = (state_q == ST_WAIT_AW_W) | (state_q == ST_WAIT_AW);
  assign wvalid_o     = (state_q == ST_WAIT_AW_W) | (state_q == ST_WAIT_W);
  assign bready_o     = (state_q == ST_WAIT_B);
  assign awid_o       = ID_WIDTH'(LSU_ID);
  assign arid_o       = ID_WIDTH'(LSU_ID);
  assign we_o         = valid_pre_i & ready_pre_o;
  assign rdata_we_o   = r_hs;
  assign beat_o       = beat_q;
  assign err_o        = err_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    split_d = split_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_pre_i) begin
          beat_d  = 1'b0;
          err_d   = 1'b0;
          split_d = (is_load | is_store) & split_i;
          if (is_load)       state_d = ST_WAIT_AR;
          else if (is_store) state_d = ST_WAIT_AW_W;
          else               state_d = ST_WAIT_READY;
        end
      end
      ST_WAIT_AR: if (arready_i) state_d = ST_WAIT_R;
      ST_WAIT_R: begin
        if (r_hs) begin
          err_d = err_q | r_bad;
          // A failing first beat ends the instruction without issuing the second.
          if (split_q && !beat_q && !r_bad) begin
            beat_d  = 1'b1;
            state_d = ST_WAIT_AR;
          end else begin
            state_d = ST_WAIT_READY;
          end
        end
      end
      ST_WAIT_AW_W: begin
        case ({awready_i, wready_i})
          2'b11:   state_d = ST_WAIT_B;
          2'b10:   state_d = ST_WAIT_W;
          2'b01:   state_d = ST_WAIT_AW;
          default: state_d = ST_WAIT_AW_W;
        endcase
      end
      ST_WAIT_AW: if (awready_i) state_d = ST_WAIT_B;
      ST_WAIT_W:  if (wready_i)  state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        if (b_hs) begin
          err_d = err_q | b_bad;
          if (split_q && !beat_q && !b_bad) begin
            beat_d  = 1'b1;
            state_d = ST_WAIT_AW_W;
          end else begin
            state_d = ST_WAIT_READY;
          end
        end
      end
      ST_WAIT_READY: if (ready_post_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == `RESET_ENABLE) begin
      state_q <= ST_IDLE;
      beat_q  <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      split_q <= split_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_PERF_COUNTERS_EN
  perf_evt_t perf_evt;
  assign perf_evt.load  = we_o & is_load;
  assign perf_evt.store = we_o & is_store;
  assign perf_evt.stall = (state_q != ST_IDLE) & (state_q != ST_WAIT_READY);

  lsu_perf_counters #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clock     (clock),
    .reset     (reset),
    .evt       (perf_evt),
    .load_cnt  (perf_load_o),
    .store_cnt (perf_store_o),
    .stall_cnt (perf_stall_o)
  );
`else
  assign perf_load_o  = '0;
  assign perf_store_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule
